// File: rtl/sampler_pkg.sv
// Shared constants and state encoding for the stereo sample playback controller.
package sampler_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int LAST_ODD  = 29399;
  localparam int LAST_EVEN = 29398;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    RD_L      = 3'd2,
    WAIT_L    = 3'd3,
    RD_R      = 3'd4,
    WAIT_R    = 3'd5,
    PRESENT   = 3'd6
  } state_e;

endpackage

// File: rtl/sampler_pair_counter.sv
// Stereo pair index with wrap at the last pair; exposes left (even) and right (odd) addresses.
module sampler_pair_counter #(
  parameter int ADDR_W   = sampler_pkg::ADDR_W,
  parameter int LAST_ODD = sampler_pkg::LAST_ODD
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              zero,
  input  logic              inc,
  output logic [ADDR_W-1:0] even_addr,
  output logic [ADDR_W-1:0] odd_addr,
  output logic              is_last
);

  localparam int             P_W    = ADDR_W - 1;
  localparam logic [P_W-1:0] LAST_P = P_W'((LAST_ODD - 1) / 2);

  logic [P_W-1:0] pair;

  always_ff @(posedge clk) begin
    if (clear || zero) begin
      pair <= '0;
    end else if (inc) begin
      pair <= is_last ? '0 : pair + P_W'(1);
    end
  end

  assign is_last   = (pair == LAST_P);
  assign even_addr = {pair, 1'b0};
  assign odd_addr  = {pair, 1'b1};

endmodule

// File: rtl/sampler_playback_ctrl.sv
// Tick-driven stereo playback sequencer: fetches one left/right pair per sample_tick
// from the sample RAM and presents it registered to the output serializer.
module sampler_playback_ctrl #(
  parameter int ADDR_W   = sampler_pkg::ADDR_W,
  parameter int DATA_W   = sampler_pkg::DATA_W,
  parameter int LAST_ODD = sampler_pkg::LAST_ODD,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  import sampler_pkg::*;

  localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT - 1);

  state_e            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] left_hold;
  logic [ADDR_W-1:0] even_addr;
  logic [ADDR_W-1:0] odd_addr;
  logic              is_last;
  logic              pair_zero;
  logic              pair_inc;
  logic              lat_done;
  logic              start_ok;

  assign start_ok  = (state == IDLE) && play && !stop;
  assign lat_done  = (lat_cnt == LAT_LAST);
  assign pair_zero = start_ok;
  assign pair_inc  = (state == PRESENT) && !stop;

  sampler_pair_counter #(
    .ADDR_W  (ADDR_W),
    .LAST_ODD(LAST_ODD)
  ) u_pair_counter (
    .clk      (clk),
    .clear    (clear),
    .zero     (pair_zero),
    .inc      (pair_inc),
    .even_addr(even_addr),
    .odd_addr (odd_addr),
    .is_last  (is_last)
  );

  // mem_addr is loaded on entry to each read state so it holds between reads.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      left_hold <= '0;
      left_out  <= '0;
      right_out <= '0;
      mem_addr  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (sample_tick && (state != IDLE) && (state != WAIT_TICK)) begin
        overrun <= 1'b1;
      end
      if (stop && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              state   <= WAIT_TICK;
              overrun <= 1'b0;
            end
          end
          WAIT_TICK: begin
            if (sample_tick) begin
              state    <= RD_L;
              mem_addr <= even_addr;
            end
          end
          RD_L: begin
            state   <= WAIT_L;
            lat_cnt <= '0;
          end
          WAIT_L: begin
            if (lat_done) begin
              left_hold <= mem_data;
              mem_addr  <= odd_addr;
              state     <= RD_R;
            end else begin
              lat_cnt <= lat_cnt + CNT_W'(1);
            end
          end
          RD_R: begin
            state   <= WAIT_R;
            lat_cnt <= '0;
          end
          WAIT_R: begin
            // Both channels update on the same edge so the serializer never sees a torn pair.
            if (lat_done) begin
              left_out  <= left_hold;
              right_out <= mem_data;
              state     <= PRESENT;
            end else begin
              lat_cnt <= lat_cnt + CNT_W'(1);
            end
          end
          PRESENT: begin
            state <= (is_last && !loop_en) ? IDLE : WAIT_TICK;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mem_rd    = (state == RD_L) || (state == RD_R);
  assign busy      = (state != IDLE);
  assign out_valid = (state == PRESENT);
  assign done      = (state == PRESENT) && is_last && !loop_en;

endmodule
